vga_scan: RTL and testbench



---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_compositor.sv | 50 +++++
 rtl/vga_scan.sv | 107 ++++++++++
 tb/tb_vga_scan.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen timing, colour type and named colours for the video path.
// Imported by the scan generator, the compositor and every sprite block.
package vga_pkg;

    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;
    localparam int H_LAST       = 639;
    localparam int V_LAST       = 479;

    localparam int COLOR_W = 6;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t BG_SKY = 6'b001011;
    localparam color_t BLACK  = 6'b000000;

endpackage

// File: rtl/vga_compositor.sv
// Priority mux over the sprite layers plus the aligned pin output registers.
// Ports: clk/reset, sample strobe, active/sync decode in, layer draw/data in,
// registered rgb/hsync/vsync/video_on out.
module vga_compositor
    import vga_pkg::*;
#(
    parameter int     NUM_LAYERS = 4,
    parameter color_t BG_COLOR   = BG_SKY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample,
    input  logic                          active,
    input  logic                          hsync_next,
    input  logic                          vsync_next,
    input  logic [NUM_LAYERS-1:0]         layer_draw,
    input  logic [COLOR_W*NUM_LAYERS-1:0] layer_data,
    output color_t                        rgb,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          video_on
);

    color_t pick;

    // Walk from the lowest priority upwards so layer 0 wins last.
    always_comb begin
        pick = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_draw[i]) begin
                pick = layer_data[COLOR_W*i +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb      <= BLACK;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (sample) begin
            rgb      <= active ? pick : BLACK;
            hsync    <= hsync_next;
            vsync    <= vsync_next;
            video_on <= active;
        end
    end

endmodule

// File: rtl/vga_scan.sv
// Raster generator: pixel phase, scan counters, sync decode, compositor.
// Ports: clk/reset, hcount/vcount/pix_en/frame_start to sprites,
// layer_draw/layer_data from sprites, rgb/hsync/vsync/video_on to the DAC.
module vga_scan
    import vga_pkg::*;
#(
    parameter int     CLK_DIV    = 4,
    parameter int     H_ACTIVE   = 640,
    parameter int     H_FP       = 16,
    parameter int     H_SYNC     = 96,
    parameter int     H_BP       = 48,
    parameter int     V_ACTIVE   = 480,
    parameter int     V_FP       = 10,
    parameter int     V_SYNC     = 2,
    parameter int     V_BP       = 33,
    parameter int     NUM_LAYERS = 4,
    parameter color_t BG_COLOR   = BG_SKY
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [9:0]                    hcount,
    output logic [9:0]                    vcount,
    output logic                          pix_en,
    output logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_draw,
    input  logic [COLOR_W*NUM_LAYERS-1:0] layer_data,
    output logic [5:0]                    rgb,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          video_on
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW    = $clog2(CLK_DIV);

    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_DIV - 2);

    localparam logic [9:0] H_MAX    = 10'(H_TOT - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [PW-1:0] phase;
    logic          active;
    logic          hsync_next;
    logic          vsync_next;
    logic          sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    assign pix_en      = (phase == PH_LAST);
    assign frame_start = pix_en && (hcount == H_MAX) && (vcount == V_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (hcount == H_MAX) begin
                hcount <= '0;
                vcount <= (vcount == V_MAX) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    assign active     = (hcount < H_ACT) && (vcount < V_ACT);
    assign hsync_next = !((hcount >= HS_START) && (hcount <= HS_END));
    assign vsync_next = !((vcount >= VS_START) && (vcount <= VS_END));

    // One clk before the pixel's last phase, so pins update with pix_en.
    assign sample = (phase == PH_SAMPLE);

    vga_compositor #(
        .NUM_LAYERS (NUM_LAYERS),
        .BG_COLOR   (BG_COLOR)
    ) u_comp (
        .clk        (clk),
        .reset      (reset),
        .sample     (sample),
        .active     (active),
        .hsync_next (hsync_next),
        .vsync_next (vsync_next),
        .layer_draw (layer_draw),
        .layer_data (layer_data),
        .rgb        (rgb),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on)
    );

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken raster: CLK_DIV=4 with registered
// layers and CLK_DIV=2 with combinational layers, checked every clk.
module tb_vga_scan;

    localparam int CD  = 4;
    localparam int CD2 = 2;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]  hcount, vcount, hcount2, vcount2;
    logic        pix_en, frame_start, hsync, vsync, video_on;
    logic        pix_en2, frame_start2, hsync2, vsync2, video_on2;
    logic [5:0]  rgb, rgb2;
    logic [3:0]  rnd_draw = 4'h0, dir_draw = 4'h0, layer_draw;
    logic [23:0] rnd_data = 24'h0, dir_data = 24'h0, layer_data;
    logic        sp_draw = 1'b0;
    logic [1:0]  l2_draw;
    logic [11:0] l2_data;

    always_comb begin
        layer_draw = rnd_draw;
        layer_data = rnd_data;
        case (mode)
            1: begin layer_draw = 4'b0001; layer_data = 24'h00003F; end
            2: begin layer_draw = dir_draw; layer_data = dir_data; end
            3: begin layer_draw = {3'b000, sp_draw}; layer_data = 24'h00002D; end
            default: ;
        endcase
    end

    // Gun-base style sprite, one clk behind the counts, overlapping the edge.
    always @(posedge clk)
        sp_draw <= (hcount >= 12 && hcount <= 16 && vcount >= 5 && vcount <= 7);

    always @(negedge clk) begin
        rnd_draw = 4'($urandom);
        rnd_data = 24'($urandom);
    end

    assign l2_draw = {hcount2 == 10'd15, hcount2 == 10'd0};
    assign l2_data = {6'h2A, 6'h15};

    vga_scan #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .NUM_LAYERS(4)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .pix_en(pix_en), .frame_start(frame_start),
        .layer_draw(layer_draw), .layer_data(layer_data),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .video_on(video_on)
    );

    vga_scan #(
        .CLK_DIV(CD2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .NUM_LAYERS(2)
    ) dut2 (
        .clk(clk), .reset(reset), .hcount(hcount2), .vcount(vcount2),
        .pix_en(pix_en2), .frame_start(frame_start2),
        .layer_draw(l2_draw), .layer_data(l2_data),
        .rgb(rgb2), .hsync(hsync2), .vsync(vsync2), .video_on(video_on2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] pick(input logic [3:0] d, input logic [23:0] dat, input int n);
        for (int i = 0; i < n; i++)
            if (d[i]) return dat[6*i +: 6];
        return 6'h0B;
    endfunction

    // Outputs a pixel produces, from its position and the layers seen at sampling.
    task automatic pixel_out(input int t, input int cd, input logic [3:0] d,
                             input logic [23:0] dat, input int n,
                             output logic [5:0] c, output bit hs, output bit vs,
                             output bit von);
        int h, v;
        h   = (t / cd) % HT;
        v   = (t / cd / HT) % VT;
        von = (h < HA) && (v < VA);
        hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        c   = von ? pick(d, dat, n) : 6'h00;
    endtask

    int t1 = 0, t2 = 0;
    bit v1 = 0, v2 = 0;
    logic [5:0] e_rgb1, e_rgb2;
    bit e_hs1, e_vs1, e_von1, e_hs2, e_vs2, e_von2;

    always @(posedge clk) begin
        if (reset) begin
            t1 = 0; v1 = 1; e_rgb1 = 0; e_hs1 = 1; e_vs1 = 1; e_von1 = 0;
            t2 = 0; v2 = 1; e_rgb2 = 0; e_hs2 = 1; e_vs2 = 1; e_von2 = 0;
        end else begin
            if (v1) begin
                if (t1 % CD == CD - 2)
                    pixel_out(t1, CD, layer_draw, layer_data, 4, e_rgb1, e_hs1, e_vs1, e_von1);
                t1++;
            end
            if (v2) begin
                if (t2 % CD2 == CD2 - 2)
                    pixel_out(t2, CD2, {2'b00, l2_draw}, {12'h000, l2_data}, 2,
                              e_rgb2, e_hs2, e_vs2, e_von2);
                t2++;
            end
        end
    end

    always @(negedge clk) begin
        int h, v;
        bit pe;
        if (v1) begin
            h  = (t1 / CD) % HT;
            v  = (t1 / CD / HT) % VT;
            pe = (t1 % CD == CD - 1);
            chk("hcount", hcount, h);
            chk("vcount", vcount, v);
            chk("pix_en", pix_en, pe);
            chk("frame_start", frame_start, pe && h == HT - 1 && v == VT - 1);
            chk("rgb", rgb, e_rgb1);
            chk("hsync", hsync, e_hs1);
            chk("vsync", vsync, e_vs1);
            chk("video_on", video_on, e_von1);
        end
        if (v2) begin
            h  = (t2 / CD2) % HT;
            v  = (t2 / CD2 / HT) % VT;
            pe = (t2 % CD2 == CD2 - 1);
            chk("hcount2", hcount2, h);
            chk("vcount2", vcount2, v);
            chk("pix_en2", pix_en2, pe);
            chk("frame_start2", frame_start2, pe && h == HT - 1 && v == VT - 1);
            chk("rgb2", rgb2, e_rgb2);
            chk("hsync2", hsync2, e_hs2);
            chk("vsync2", vsync2, e_vs2);
            chk("video_on2", video_on2, e_von2);
        end
    end

    task automatic wait_hv(input int h, input int v);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hcount == h && vcount == v) return;
        end
        chk("wait_hv_timeout", 0, 1);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        chk("wait_fs_timeout", 0, 1);
    endtask

    task automatic wait2(input int h, input int v);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hcount2 == h && vcount2 == v && pix_en2) return;
        end
        chk("wait2_timeout", 0, 1);
    endtask

    initial begin
        int n, c0, lowc;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (pix_en) break;
        end
        chk("pix_en_clk", n, 4);

        wait_hv(6, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_h", hcount, 0);
        chk("reset_v", vcount, 0);
        chk("reset_hsync", hsync, 1);
        chk("reset_vsync", vsync, 1);
        chk("reset_rgb", rgb, 0);
        chk("reset_von", video_on, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        wait_fs();
        c0 = cyc;
        chk("fs_h", hcount, HT - 1);
        chk("fs_v", vcount, VT - 1);
        chk("fs_pix", pix_en, 1);
        wait_fs();
        chk("frame_period", cyc - c0, 1104);

        wait_hv(0, 2);
        lowc = 0;
        repeat (HT * CD) begin
            if (!hsync) lowc++;
            @(negedge clk);
        end
        chk("hsync_low_clks", lowc, 12);

        mode = 1;
        wait_fs();
        wait_fs();
        wait_hv(15, 1);
        repeat (3) @(negedge clk);
        chk("blank_in_rgb", rgb, 6'h3F);
        chk("blank_in_von", video_on, 1);
        repeat (4) @(negedge clk);
        chk("blank_edge_rgb", rgb, 0);
        chk("blank_edge_von", video_on, 0);

        dir_draw = 4'b1010;
        dir_data = {6'h0C, 6'h00, 6'h30, 6'h00};
        mode = 2;
        wait_hv(4, 2);
        repeat (3) @(negedge clk);
        chk("prio_l1_l3", rgb, 6'h30);
        dir_draw = 4'b1000;
        repeat (4) @(negedge clk);
        chk("prio_l3", rgb, 6'h0C);
        dir_draw = 4'b0000;
        repeat (4) @(negedge clk);
        chk("prio_none", rgb, 6'h0B);

        mode = 3;
        wait_fs();
        wait_hv(12, 5);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (rgb == 6'h2D) break;
            @(negedge clk);
            n++;
        end
        chk("sprite_latency", n, CD - 1);
        wait_hv(16, 5);
        repeat (3) @(negedge clk);
        chk("sprite_col16", rgb, 0);

        wait2(0, 1);
        chk("cd2_h0", rgb2, 6'h15);
        wait2(14, 1);
        chk("cd2_h14", rgb2, 6'h0B);
        wait2(15, 1);
        chk("cd2_h15", rgb2, 6'h2A);

        mode = 0;
        wait_fs();
        wait_fs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
